// File: rtl/spi_ram_ctrl_if.sv
// spi_ram_ctrl_if: link between the SPI slave and spi_ram_ctrl.
//   rx_data[9:0] : command word, [9:8] opcode, [7:0] payload (SPI slave -> ctrl)
//   rx_valid     : command qualifier, one command per rising edge (SPI slave -> ctrl)
//   tx_data[7:0] : read byte for MISO serialisation (ctrl -> SPI slave)
//   tx_valid     : tx_data valid, held until the next accepted command (ctrl -> SPI slave)
//   addr_err     : sticky out-of-range access flag (ctrl -> SPI slave)
interface spi_ram_ctrl_if;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       addr_err;

    modport master (
        output rx_data, rx_valid,
        input  tx_data, tx_valid, addr_err
    );

    modport slave (
        input  rx_data, rx_valid,
        output tx_data, tx_valid, addr_err
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: single-port RAM behind the SPI slave. Decodes 10-bit command
// words into address-load, write and read operations; auto-incrementing
// read/write pointers wrap at MEM_DEPTH-1; out-of-range data accesses set a
// sticky error flag and clear the offending pointer.
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : spi_ram_ctrl_if.slave (rx_data/rx_valid in; tx_data/tx_valid/addr_err out)
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    spi_ram_ctrl_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } opcode_t;

    logic [7:0]           r_mem [MEM_DEPTH];
    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_rx_valid_d;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic [7:0]           r_tx_data;
    logic                 r_addr_err;
    logic                 w_accept;
    opcode_t              w_op;
    logic                 w_wr_oor;
    logic                 w_rd_oor;

    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (int'(a) == MEM_DEPTH - 1) ? '0 : a + ADDR_SIZE'(1);
    endfunction

    // Edge detect on rx_valid; r_rx_valid_d resets high so a command still
    // asserted across reset release is ignored until rx_valid drops.
    assign w_accept = bus.rx_valid & ~r_rx_valid_d;
    assign w_op     = opcode_t'(bus.rx_data[9:8]);
    assign w_wr_oor = (int'(r_wr_addr) >= MEM_DEPTH);
    assign w_rd_oor = (int'(r_rd_addr) >= MEM_DEPTH);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state: any accepted command decides; RD_DATA holds tx_valid high
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = (w_op == RD_DATA) ? HOLD : IDLE;
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rx_valid_d <= 1'b1;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_tx_data    <= '0;
            r_addr_err   <= 1'b0;
        end else begin
            r_rx_valid_d <= bus.rx_valid;
            if (w_accept) begin
                case (w_op)
                    WR_ADDR: r_wr_addr <= bus.rx_data[ADDR_SIZE-1:0];
                    WR_DATA: begin
                        if (w_wr_oor) begin
                            r_addr_err <= 1'b1;
                            r_wr_addr  <= '0;
                        end else begin
                            r_wr_addr  <= next_addr(r_wr_addr);
                        end
                    end
                    RD_ADDR: r_rd_addr <= bus.rx_data[ADDR_SIZE-1:0];
                    RD_DATA: begin
                        if (w_rd_oor) begin
                            r_tx_data  <= '0;
                            r_addr_err <= 1'b1;
                            r_rd_addr  <= '0;
                        end else begin
                            r_tx_data  <= r_mem[r_rd_addr];
                            r_rd_addr  <= next_addr(r_rd_addr);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Memory array, intentionally not reset
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_accept && (w_op == WR_DATA) && !w_wr_oor) begin
            r_mem[r_wr_addr] <= bus.rx_data[7:0];
        end
    end

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = (r_state == HOLD);
    assign bus.addr_err = r_addr_err;
endmodule
